// File: rtl/swarm_runtime_cfg.sv
// Run-time configuration registers: per-tile shadows written by the host, copied
// atomically to the active outputs by a COMMIT once every tile is quiesced.
module swarm_runtime_cfg #(
  parameter int N_TILES           = 1,
  parameter int N_LOG_SRC         = 8,
  parameter int LOG_CQ_SLICE_SIZE = 7,
  parameter int VERSION           = 10,
  parameter int COMMIT_TIMEOUT    = 1024
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic                                        reg_valid,
  output logic                                        reg_ready,
  input  logic                                        reg_wr,
  input  logic [7:0]                                  reg_addr,
  input  logic [31:0]                                 reg_wdata,
  output logic                                        rd_valid,
  output logic [31:0]                                 rd_data,
  input  logic [N_TILES-1:0]                          tile_quiesced,
  output logic [N_TILES*N_LOG_SRC-1:0]                cfg_log_en,
  output logic [N_TILES*4-1:0]                        cfg_gvt_period,
  output logic [N_TILES*(LOG_CQ_SLICE_SIZE+1)-1:0]    cfg_cq_limit,
  output logic                                        cfg_update
);

  localparam int CQW = LOG_CQ_SLICE_SIZE + 1;
  localparam int TW  = $clog2(COMMIT_TIMEOUT);
  localparam logic [CQW-1:0] CQ_MAX = {1'b1, {LOG_CQ_SLICE_SIZE{1'b0}}};
  localparam logic [CQW-1:0] CQ_ONE = {{(CQW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]  WAIT_LAST = TW'(COMMIT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

  state_t                       state;
  logic [TW-1:0]                wait_cnt;
  logic                         err;
  logic [15:0]                  commit_cnt;
  logic [N_TILES*N_LOG_SRC-1:0] shadow_log_en;
  logic [N_TILES*4-1:0]         shadow_gvt;
  logic [N_TILES*CQW-1:0]       shadow_cq;

  logic [3:0]           tile_f;
  logic [3:0]           reg_f;
  logic                 tile_ok;
  logic                 bcast;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 commit_wr;
  logic                 status_wr;
  logic [31:0]          status;
  logic [31:0]          rd_mux;
  logic [N_LOG_SRC-1:0] sel_log;
  logic [3:0]           sel_gvt;
  logic [CQW-1:0]       sel_cq;

  function automatic logic [3:0] clamp_gvt(input logic [31:0] v);
    if (v < 32'd2)       return 4'd2;
    else if (v > 32'd15) return 4'd15;
    else                 return v[3:0];
  endfunction

  function automatic logic [CQW-1:0] clamp_cq(input logic [31:0] v);
    if (v == 32'd0)            return CQ_ONE;
    else if (v > 32'(CQ_MAX))  return CQ_MAX;
    else                       return v[CQW-1:0];
  endfunction

  assign tile_f    = reg_addr[7:4];
  assign reg_f     = reg_addr[3:0];
  assign tile_ok   = (int'(tile_f) < N_TILES);
  assign bcast     = (tile_f == 4'hF);
  // Writes stall while a commit waits for quiesce so the shadows stay frozen.
  assign reg_ready = (state == PEND) ? ~reg_wr : 1'b1;
  assign wr_acc    = reg_valid & reg_ready & reg_wr;
  assign rd_acc    = reg_valid & reg_ready & ~reg_wr;
  assign commit_wr = wr_acc && (reg_f == 4'd10);
  assign status_wr = wr_acc && (reg_f == 4'd9);
  assign status    = {err, (state != IDLE), 14'b0, commit_cnt};

  always_comb begin
    sel_log = '0;
    sel_gvt = '0;
    sel_cq  = '0;
    for (int t = 0; t < N_TILES; t++) begin
      if (tile_f == 4'(t)) begin
        sel_log = shadow_log_en[t*N_LOG_SRC +: N_LOG_SRC];
        sel_gvt = shadow_gvt[t*4 +: 4];
        sel_cq  = shadow_cq[t*CQW +: CQW];
      end
    end
    rd_mux = 32'hDEAD_BEEF;
    case (reg_f)
      4'd0:    if (tile_ok) rd_mux = 32'(sel_log);
      4'd1:    if (tile_ok) rd_mux = 32'(sel_gvt);
      4'd2:    if (tile_ok) rd_mux = 32'(sel_cq);
      4'd8:    rd_mux = 32'(VERSION);
      4'd9:    rd_mux = status;
      4'd10:   rd_mux = 32'd0;
      default: rd_mux = 32'hDEAD_BEEF;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_log_en <= '0;
      shadow_gvt    <= {N_TILES{4'd5}};
      shadow_cq     <= {N_TILES{CQ_MAX}};
    end else if (wr_acc) begin
      for (int t = 0; t < N_TILES; t++) begin
        if (bcast || (tile_f == 4'(t))) begin
          case (reg_f)
            4'd0:    shadow_log_en[t*N_LOG_SRC +: N_LOG_SRC] <= reg_wdata[N_LOG_SRC-1:0];
            4'd1:    shadow_gvt[t*4 +: 4]                    <= clamp_gvt(reg_wdata);
            4'd2:    shadow_cq[t*CQW +: CQW]                 <= clamp_cq(reg_wdata);
            default: ;
          endcase
        end
      end
    end
  end

  // Read response stage: one cycle after acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) rd_data <= rd_mux;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      err            <= 1'b0;
      commit_cnt     <= '0;
      cfg_update     <= 1'b0;
      cfg_log_en     <= '0;
      cfg_gvt_period <= {N_TILES{4'd5}};
      cfg_cq_limit   <= {N_TILES{CQ_MAX}};
    end else begin
      cfg_update <= 1'b0;
      if (status_wr) err <= 1'b0;
      case (state)
        IDLE: begin
          if (commit_wr) begin
            state    <= PEND;
            wait_cnt <= '0;
          end
        end
        PEND: begin
          if (&tile_quiesced) begin
            state <= APPLY;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        APPLY: begin
          cfg_log_en     <= shadow_log_en;
          cfg_gvt_period <= shadow_gvt;
          cfg_cq_limit   <= shadow_cq;
          cfg_update     <= 1'b1;
          commit_cnt     <= commit_cnt + 16'd1;
          wait_cnt       <= '0;
          state          <= commit_wr ? PEND : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
